fb_rect_fill: RTL and testbench

Hardware rectangle-fill engine that writes the 256 x 128 1-bit frame buffer through its read/write port (port A), on behalf of the microprocessor. The CPU supplies two corner coordinates and a colour, pulses START, and the block sweeps the rectangle in raster order, one pixel write per cycle. The VGA side keeps reading the buffer through port B. This block is the writer end of that interface.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_raster_counter.sv | 50 +++++
 rtl/fb_rect_fill.sv | 160 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry, fill-engine state encoding and the {y,x} address packing.
// READ state exists only when FB_RECT_XOR_EN is defined.
package fb_pkg;

  localparam int FB_X_WIDTH    = 8;
  localparam int FB_Y_WIDTH    = 7;
  localparam int FB_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DONE_ST = 2'd2
`ifdef FB_RECT_XOR_EN
    ,
    READ    = 2'd3
`endif
  } fill_state_t;

  // Same packing is used by the frame buffer and the VGA reader: row in the MSBs.
  function automatic logic [FB_ADDR_WIDTH-1:0] fb_addr_pack(
    input logic [FB_Y_WIDTH-1:0] y,
    input logic [FB_X_WIDTH-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order x/y walker over a latched rectangle; x wraps to xl and y steps when x reaches xh.
module fb_raster_counter #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [X_WIDTH-1:0] xl,
  input  logic [X_WIDTH-1:0] xh,
  input  logic [Y_WIDTH-1:0] yl,
  input  logic [Y_WIDTH-1:0] yh,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               last
);

  logic [X_WIDTH-1:0] x_reg, xl_reg, xh_reg;
  logic [Y_WIDTH-1:0] y_reg, yh_reg;

  // Compare before increment: the sequencer never advances on the last pixel, so no wrap is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg  <= '0;
      y_reg  <= '0;
      xl_reg <= '0;
      xh_reg <= '0;
      yh_reg <= '0;
    end else if (load) begin
      x_reg  <= xl;
      y_reg  <= yl;
      xl_reg <= xl;
      xh_reg <= xh;
      yh_reg <= yh;
    end else if (advance) begin
      if (x_reg == xh_reg) begin
        x_reg <= xl_reg;
        y_reg <= y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = (x_reg == xh_reg) && (y_reg == yh_reg);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine writing the 1-bit frame buffer through port A, one pixel per cycle.
// Define FB_RECT_XOR_EN to add the XOR input and the read-modify-write READ state.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int X_WIDTH = FB_X_WIDTH,
  parameter int Y_WIDTH = FB_Y_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       START,
  input  logic                       ABORT,
  input  logic [X_WIDTH-1:0]         X0,
  input  logic [X_WIDTH-1:0]         X1,
  input  logic [Y_WIDTH-1:0]         Y0,
  input  logic [Y_WIDTH-1:0]         Y1,
  input  logic                       COLOUR,
`ifdef FB_RECT_XOR_EN
  input  logic                       XOR,
`endif
  output logic                       BUSY,
  output logic                       DONE,
  output logic [X_WIDTH+Y_WIDTH-1:0] FB_ADDR,
  output logic                       FB_DATA,
  output logic                       FB_WE,
  input  logic                       FB_RDATA
);

  fill_state_t state_reg, state_next;
  logic we_reg, we_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic colour_reg;
  logic load, advance, last;
  logic [X_WIDTH-1:0] xl, xh, x;
  logic [Y_WIDTH-1:0] yl, yh, y;

  assign xl = (X0 < X1) ? X0 : X1;
  assign xh = (X0 < X1) ? X1 : X0;
  assign yl = (Y0 < Y1) ? Y0 : Y1;
  assign yh = (Y0 < Y1) ? Y1 : Y0;

  fb_raster_counter #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_counter (
    .clk     (CLK),
    .rst_n   (RESETN),
    .load    (load),
    .advance (advance),
    .xl      (xl),
    .xh      (xh),
    .yl      (yl),
    .yh      (yh),
    .x       (x),
    .y       (y),
    .last    (last)
  );

`ifdef FB_RECT_XOR_EN
  logic xor_reg;
`else
  logic unused_rdata;
  assign unused_rdata = FB_RDATA;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      colour_reg <= 1'b0;
`ifdef FB_RECT_XOR_EN
      xor_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      if (load) begin
        colour_reg <= COLOUR;
`ifdef FB_RECT_XOR_EN
        xor_reg    <= XOR;
`endif
      end
    end
  end

  // BUSY is already low while DONE is shown, so START is accepted in DONE_ST as well as IDLE.
  always_comb begin
    state_next = state_reg;
    we_next    = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE, DONE_ST: begin
        state_next = IDLE;
        if (START) begin
          load       = 1'b1;
          busy_next  = 1'b1;
          state_next = FILL;
          we_next    = 1'b1;
`ifdef FB_RECT_XOR_EN
          if (XOR) begin
            state_next = READ;
            we_next    = 1'b0;
          end
`endif
        end
      end
      FILL: begin
        if (ABORT) begin
          state_next = IDLE;
        end else if (last) begin
          state_next = DONE_ST;
          done_next  = 1'b1;
        end else begin
          advance    = 1'b1;
          busy_next  = 1'b1;
          state_next = FILL;
          we_next    = 1'b1;
`ifdef FB_RECT_XOR_EN
          if (xor_reg) begin
            state_next = READ;
            we_next    = 1'b0;
          end
`endif
        end
      end
`ifdef FB_RECT_XOR_EN
      READ: begin
        if (ABORT) begin
          state_next = IDLE;
        end else begin
          state_next = FILL;
          busy_next  = 1'b1;
          we_next    = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign FB_WE   = we_reg;
  assign FB_ADDR = fb_addr_pack(y, x);
`ifdef FB_RECT_XOR_EN
  // Port-A read data arrives one cycle after READ presented the address, i.e. during FILL.
  assign FB_DATA = colour_reg ^ (xor_reg & FB_RDATA);
`else
  assign FB_DATA = colour_reg;
`endif

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: a frame-buffer model on port A plus a raster reference model of expected writes.
// Compile with FB_RECT_XOR_EN to also exercise XOR mode.
module tb_fb_rect_fill;

  logic        CLK = 1'b0;
  logic        RESETN, START, ABORT, COLOUR, FB_RDATA;
  logic [7:0]  X0, X1;
  logic [6:0]  Y0, Y1;
  logic        BUSY, DONE, FB_DATA, FB_WE;
  logic [14:0] FB_ADDR;
`ifdef FB_RECT_XOR_EN
  logic        XOR;
`endif

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  bit fb_mem  [32768];
  bit exp_mem [32768];
  logic [14:0] got_addr[$];
  logic        got_data[$];
  int          got_j[$];

  always #5 CLK = ~CLK;

  fb_rect_fill dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .START    (START),
    .ABORT    (ABORT),
    .X0       (X0),
    .X1       (X1),
    .Y0       (Y0),
    .Y1       (Y1),
    .COLOUR   (COLOUR),
`ifdef FB_RECT_XOR_EN
    .XOR      (XOR),
`endif
    .BUSY     (BUSY),
    .DONE     (DONE),
    .FB_ADDR  (FB_ADDR),
    .FB_DATA  (FB_DATA),
    .FB_WE    (FB_WE),
    .FB_RDATA (FB_RDATA)
  );

  // Port-A memory: registered read, write on FB_WE.
  always @(posedge CLK) begin
    if (FB_WE === 1'b1) begin
      fb_mem[FB_ADDR] <= FB_DATA;
      wr_total        <= wr_total + 1;
    end
    FB_RDATA <= fb_mem[FB_ADDR];
  end

  task automatic set_rect(input int x0, x1, y0, y1, input bit col, input bit xr);
    X0 = 8'(x0); X1 = 8'(x1); Y0 = 7'(y0); Y1 = 7'(y1); COLOUR = col;
`ifdef FB_RECT_XOR_EN
    XOR = xr;
`endif
  endtask

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < 32768; i++) if (fb_mem[i] != exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s memory: %0d pixels differ, required 0", name, bad);
    end
  endtask

  // Starts a fill, gathers every write until DONE, then checks it against the raster model.
  task automatic run_fill(input int x0, x1, y0, y1, input bit col, input bit xr, input bit ab,
                          input bit chain_in, input bit chain_out, input string name);
    int xl, xh, yl, yh, n, per, done_j, busy_cnt, bad, k, a;
    bit d;
    xl = (x0 < x1) ? x0 : x1; xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1; yh = (y0 < y1) ? y1 : y0;
    n = (xh - xl + 1) * (yh - yl + 1);
    per = xr ? 2 : 1;
    if (!chain_in) @(negedge CLK);
    set_rect(x0, x1, y0, y1, col, xr);
    START = 1'b1; ABORT = ab;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    got_addr.delete(); got_data.delete(); got_j.delete();
    done_j = 0; busy_cnt = 0;
    for (int j = 1; j <= per * n + 20; j++) begin
      if (j > 1) @(negedge CLK);
      if (FB_WE === 1'b1) begin
        got_addr.push_back(FB_ADDR); got_data.push_back(FB_DATA); got_j.push_back(j);
      end
      if (BUSY === 1'b1) busy_cnt++;
      if (DONE === 1'b1) begin done_j = j; break; end
    end
    bad = 0; k = 0;
    for (int yy = yl; yy <= yh; yy++) begin
      for (int xx = xl; xx <= xh; xx++) begin
        a = yy * 256 + xx;
        d = xr ? (exp_mem[a] ^ col) : col;
        exp_mem[a] = d;
        if (k >= got_addr.size()) bad++;
        else if (got_addr[k] !== 15'(a) || got_data[k] !== d || got_j[k] != per * (k + 1)) bad++;
        k++;
      end
    end
    checks++;
    if (got_addr.size() != n) begin
      errors++; $display("FAIL %s write_count: got %0d, required %0d", name, got_addr.size(), n);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s write_order: %0d writes wrong, required 0", name, bad);
    end
    checks++;
    if (done_j != per * n + 1) begin
      errors++; $display("FAIL %s done_time: got t+%0d, required t+%0d", name, done_j, per * n + 1);
    end
    checks++;
    if (busy_cnt != per * n) begin
      errors++; $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, per * n);
    end
    if (!chain_out) begin
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || FB_WE !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_after: done=%b busy=%b we=%b, required 0 0 0", name, DONE, BUSY, FB_WE);
      end
    end
    mem_check(name);
    $display("fill %s: (%0d,%0d)-(%0d,%0d) colour=%0d xor=%0d writes=%0d done=t+%0d",
             name, x0, y0, x1, y1, col, xr, got_addr.size(), done_j);
  endtask

  task automatic test_reset();
    RESETN = 1'b0; START = 1'b1; ABORT = 1'b0;
    set_rect(0, 5, 0, 5, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", BUSY); end
    checks++;
    if (FB_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", FB_WE); end
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", DONE); end
    checks++;
    if (FB_ADDR !== 15'h0000) begin errors++; $display("FAIL reset_addr: got %h, required 0000", FB_ADDR); end
    checks++;
    if (FB_DATA !== 1'b0) begin errors++; $display("FAIL reset_data: got %b, required 0", FB_DATA); end
    checks++;
    if (wr_total != 0) begin errors++; $display("FAIL reset_writes: got %0d, required 0", wr_total); end
    START = 1'b0;
    RESETN = 1'b1;
    $display("reset: busy=%b we=%b done=%b addr=%h", BUSY, FB_WE, DONE, FB_ADDR);
    run_fill(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "single_pixel");
  endtask

  task automatic test_swapped();
    logic [14:0] want [8];
    int bad = 0;
    want = '{15'h0207, 15'h0208, 15'h0209, 15'h020A, 15'h0307, 15'h0308, 15'h0309, 15'h030A};
    run_fill(10, 7, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "swapped");
    for (int i = 0; i < 8; i++) if (i >= got_addr.size() || got_addr[i] !== want[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL swapped_addresses: %0d of 8 wrong, required 0", bad); end
  endtask

  task automatic test_full_screen();
    run_fill(0, 255, 0, 127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "full_screen");
    checks++;
    if (got_addr.size() == 0 || got_addr[got_addr.size() - 1] !== 15'h7FFF) begin
      errors++;
      $display("FAIL full_screen_last: got %h, required 7fff",
               (got_addr.size() == 0) ? 15'h0 : got_addr[got_addr.size() - 1]);
    end
  endtask

  task automatic test_start_abort();
    int wr0;
    // ABORT alone in IDLE must do nothing.
    wr0 = wr_total;
    @(negedge CLK); ABORT = 1'b1;
    repeat (3) @(negedge CLK);
    ABORT = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || wr_total != wr0) begin
      errors++; $display("FAIL idle_abort: busy=%b writes=%0d, required 0 0", BUSY, wr_total - wr0);
    end
    run_fill(3, 9, 100, 101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start_with_abort");
  endtask

  task automatic test_abort_busy();
    int wr0, seen, extra_we, extra_done;
    wr0 = wr_total; seen = 0;
    @(negedge CLK);
    set_rect(10, 109, 5, 104, 1'b1, 1'b0);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int j = 1; j <= 50; j++) begin
      if (j > 1) @(negedge CLK);
      if (FB_WE === 1'b1) seen++;
      START = (j == 20);
      if (j == 20) set_rect(0, 0, 0, 0, 1'b0, 1'b0);
      ABORT = (j == 50);
    end
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    checks++;
    if (FB_WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL abort_next: we=%b busy=%b done=%b, required 0 0 0", FB_WE, BUSY, DONE);
    end
    checks++;
    if (seen != 50) begin errors++; $display("FAIL abort_writes_seen: got %0d, required 50", seen); end
    extra_we = 0; extra_done = 0;
    repeat (10) begin
      @(negedge CLK);
      if (FB_WE === 1'b1) extra_we++;
      if (DONE === 1'b1) extra_done++;
    end
    checks++;
    if (extra_we != 0 || extra_done != 0) begin
      errors++; $display("FAIL abort_quiet: writes=%0d done=%0d, required 0 0", extra_we, extra_done);
    end
    checks++;
    if (wr_total - wr0 != 50) begin
      errors++; $display("FAIL abort_total: got %0d writes, required 50", wr_total - wr0);
    end
    for (int xx = 10; xx < 60; xx++) exp_mem[5 * 256 + xx] = 1'b1;
    mem_check("abort");
    $display("abort: writes=%0d busy=%b", wr_total - wr0, BUSY);
  endtask

  task automatic test_async_reset();
    int wr0, late_we, late_busy;
    wr0 = wr_total;
    @(negedge CLK);
    set_rect(20, 69, 40, 49, 1'b1, 1'b0);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (29) @(negedge CLK);
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (FB_WE !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL async_reset_now: we=%b busy=%b, required 0 0", FB_WE, BUSY);
    end
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    late_we = 0; late_busy = 0;
    repeat (20) begin
      @(negedge CLK);
      if (FB_WE === 1'b1) late_we++;
      if (BUSY === 1'b1) late_busy++;
    end
    checks++;
    if (late_we != 0 || late_busy != 0) begin
      errors++; $display("FAIL async_no_resume: writes=%0d busy=%0d, required 0 0", late_we, late_busy);
    end
    checks++;
    if (wr_total - wr0 != 29) begin
      errors++; $display("FAIL async_total: got %0d writes, required 29", wr_total - wr0);
    end
    for (int xx = 20; xx < 49; xx++) exp_mem[40 * 256 + xx] = 1'b1;
    mem_check("async_reset");
    $display("async reset: writes before reset=%0d", wr_total - wr0);
  endtask

  task automatic test_back_to_back();
    run_fill(50, 52, 60, 61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_first");
    run_fill(53, 50, 62, 60, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_second");
  endtask

`ifdef FB_RECT_XOR_EN
  task automatic test_xor();
    run_fill(5, 5, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "xor_preset");
    run_fill(4, 6, 5, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "xor_fill");
    checks++;
    if (fb_mem[5 * 256 + 4] != 1'b1 || fb_mem[5 * 256 + 5] != 1'b0 || fb_mem[5 * 256 + 6] != 1'b1) begin
      errors++;
      $display("FAIL xor_pixels: got %0d%0d%0d, required 101",
               fb_mem[5 * 256 + 4], fb_mem[5 * 256 + 5], fb_mem[5 * 256 + 6]);
    end
  endtask
`endif

  task automatic test_random();
    int x0, x1, y0, y1;
    bit col, xr;
    for (int i = 0; i < 6; i++) begin
      x0 = $urandom_range(0, 255);
      y0 = $urandom_range(0, 127);
      x1 = x0 + $urandom_range(0, 30) - 15;
      y1 = y0 + $urandom_range(0, 16) - 8;
      if (x1 < 0) x1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0;
      if (y1 > 127) y1 = 127;
      col = 1'($urandom_range(0, 1));
`ifdef FB_RECT_XOR_EN
      xr = 1'($urandom_range(0, 1));
`else
      xr = 1'b0;
`endif
      run_fill(x0, x1, y0, y1, col, xr, 1'b0, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    RESETN = 1'b0; START = 1'b0; ABORT = 1'b0;
    set_rect(0, 0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_swapped();
    test_full_screen();
`ifdef FB_RECT_XOR_EN
    test_xor();
`endif
    test_start_abort();
    test_abort_busy();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
